// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : frame_loader
// Brief    : Loads packed pixel-pair words into the back bank of a
//            double-buffered pixel RAM; swaps banks on display frame start.
// Revision : 1.0 - initial release
// ============================================================================
module frame_loader #(
    parameter int ADDR_W = 11,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    input  logic              word_first,
    input  logic              disp_frame_start,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_waddr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic              disp_bank,
    output logic              frame_ready,
    output logic [7:0]        frames_loaded,
    output logic              short_frame,
    output logic              overrun
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD      = 2'd1;
    localparam logic [1:0] S_WAIT_SWAP = 2'd2;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_count;
    logic              r_we;
    logic [ADDR_W:0]   r_waddr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_disp_bank;
    logic              r_frame_ready;
    logic [7:0]        r_frames_loaded;
    logic              r_short;
    logic              r_overrun;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_count_nxt;
    logic [ADDR_W-1:0] w_base;
    logic              w_we_nxt;
    logic [ADDR_W:0]   w_waddr_nxt;
    logic [WORD_W-1:0] w_wdata_nxt;
    logic              w_short_nxt;
    logic              w_overrun_nxt;
    logic              w_swap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_count         <= '0;
            r_we            <= 1'b0;
            r_waddr         <= '0;
            r_wdata         <= '0;
            r_disp_bank     <= 1'b0;
            r_frame_ready   <= 1'b0;
            r_frames_loaded <= 8'd0;
            r_short         <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_we      <= w_we_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_short   <= w_short_nxt;
            r_overrun <= w_overrun_nxt;
            if (w_swap) begin
                r_disp_bank     <= ~r_disp_bank;
                r_frame_ready   <= 1'b1;
                r_frames_loaded <= r_frames_loaded + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_base        = r_count;
        w_we_nxt      = 1'b0;
        w_waddr_nxt   = r_waddr;
        w_wdata_nxt   = r_wdata;
        w_short_nxt   = 1'b0;
        w_overrun_nxt = r_overrun;
        w_swap        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (word_first) begin
                    w_state_nxt = S_LOAD;
                    w_base      = '0;
                    w_count_nxt = '0;
                    if (word_valid) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = {~r_disp_bank, w_base};
                        w_wdata_nxt = word_data;
                        w_count_nxt = w_base + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // A restart only counts as a short frame if words were already taken
                if (word_first) begin
                    w_base      = '0;
                    w_short_nxt = (r_count != '0);
                end
                w_count_nxt = w_base;
                if (word_valid) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = {~r_disp_bank, w_base};
                    w_wdata_nxt = word_data;
                    if (w_base == c_LAST_ADDR) begin
                        w_state_nxt = S_WAIT_SWAP;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = w_base + 1'b1;
                    end
                end
            end
            S_WAIT_SWAP: begin
                if (word_valid || word_first) begin
                    w_overrun_nxt = 1'b1;
                end
                if (disp_frame_start) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign ram_we        = r_we;
    assign ram_waddr     = r_waddr;
    assign ram_wdata     = r_wdata;
    assign disp_bank     = r_disp_bank;
    assign frame_ready   = r_frame_ready;
    assign frames_loaded = r_frames_loaded;
    assign short_frame   = r_short;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_loader
// Brief    : Scoreboard bench for frame_loader; a small-frame second instance
//            exercises the frames_loaded wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_loader;

    localparam int AW  = 11;
    localparam int WW  = 32;
    localparam int SAW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [WW-1:0] word_data;
    logic          word_valid, word_first, disp_frame_start;
    logic          ram_we;
    logic [AW:0]   ram_waddr;
    logic [WW-1:0] ram_wdata;
    logic          disp_bank, frame_ready, short_frame, overrun;
    logic [7:0]    frames_loaded;

    logic [WW-1:0] s_word_data;
    logic          s_word_valid, s_word_first, s_disp_frame_start;
    logic          s_ram_we;
    logic [SAW:0]  s_ram_waddr;
    logic [WW-1:0] s_ram_wdata;
    logic          s_disp_bank, s_frame_ready, s_short_frame, s_overrun;
    logic [7:0]    s_frames_loaded;

    frame_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk(clk), .reset(reset), .word_data(word_data), .word_valid(word_valid),
        .word_first(word_first), .disp_frame_start(disp_frame_start),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .disp_bank(disp_bank), .frame_ready(frame_ready), .frames_loaded(frames_loaded),
        .short_frame(short_frame), .overrun(overrun)
    );

    frame_loader #(.ADDR_W(SAW), .WORD_W(WW)) dut_small (
        .clk(clk), .reset(reset), .word_data(s_word_data), .word_valid(s_word_valid),
        .word_first(s_word_first), .disp_frame_start(s_disp_frame_start),
        .ram_we(s_ram_we), .ram_waddr(s_ram_waddr), .ram_wdata(s_ram_wdata),
        .disp_bank(s_disp_bank), .frame_ready(s_frame_ready), .frames_loaded(s_frames_loaded),
        .short_frame(s_short_frame), .overrun(s_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [AW:0]   addr;
        logic [WW-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    task automatic push(input logic bank, input int idx, input logic [WW-1:0] d);
        wr_t e;
        logic [AW-1:0] a;
        a      = idx[AW-1:0];
        e.addr = {bank, a};
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Every RAM write must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", ram_we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", ram_waddr, e.addr);
                check("wr_data", ram_wdata, e.data);
            end
        end
    end

    task automatic cyc(input logic v, input logic f, input logic dfs, input logic [WW-1:0] d);
        word_valid = v; word_first = f; disp_frame_start = dfs; word_data = d;
        @(posedge clk); #1;
        word_valid = 1'b0; word_first = 1'b0; disp_frame_start = 1'b0;
    endtask

    task automatic s_cyc(input logic v, input logic f, input logic dfs);
        s_word_valid = v; s_word_first = f; s_disp_frame_start = dfs; s_word_data = $urandom;
        @(posedge clk); #1;
        s_word_valid = 1'b0; s_word_first = 1'b0; s_disp_frame_start = 1'b0;
    endtask

    task automatic load_frame(input logic bank, input logic [WW-1:0] base);
        cyc(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 2048; i++) begin
            push(bank, i, base + i);
            cyc(1'b1, 1'b0, 1'b0, base + i);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_we"},     ram_we,        1'b0);
        check({pfx, "_waddr"},  ram_waddr,     '0);
        check({pfx, "_wdata"},  ram_wdata,     '0);
        check({pfx, "_bank"},   disp_bank,     1'b0);
        check({pfx, "_ready"},  frame_ready,   1'b0);
        check({pfx, "_frames"}, frames_loaded, 8'd0);
        check({pfx, "_short"},  short_frame,   1'b0);
        check({pfx, "_overrun"}, overrun,      1'b0);
    endtask

    initial begin
        reset = 1'b1;
        word_valid = 1'b0; word_first = 1'b0; disp_frame_start = 1'b0; word_data = '0;
        s_word_valid = 1'b0; s_word_first = 1'b0; s_disp_frame_start = 1'b0; s_word_data = '0;
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Stray words in IDLE are ignored
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 32'hDEAD_0000 + i);
        check("idle_short", short_frame, 1'b0);
        check("idle_overrun", overrun, 1'b0);

        // First frame into bank 1, data = index
        load_frame(1'b1, 32'h0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
        check("f1_noswap_bank", disp_bank, 1'b0);
        check("f1_noswap_ready", frame_ready, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("f1_bank", disp_bank, 1'b1);
        check("f1_ready", frame_ready, 1'b1);
        check("f1_frames", frames_loaded, 8'd1);
        check("f1_overrun", overrun, 1'b0);

        // Second frame into bank 0
        load_frame(1'b0, 32'h1000_0000);
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("f2_bank", disp_bank, 1'b0);
        check("f2_frames", frames_loaded, 8'd2);

        // Short frame restart after 100 words
        cyc(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 100; i++) begin
            push(1'b1, i, 32'h2000_0000 + i);
            cyc(1'b1, 1'b0, 1'b0, 32'h2000_0000 + i);
        end
        push(1'b1, 0, 32'hA5A5_A5A5);
        cyc(1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5);
        check("short_pulse", short_frame, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("short_clear", short_frame, 1'b0);
        for (int i = 1; i < 2047; i++) begin
            push(1'b1, i, 32'h3000_0000 + i);
            cyc(1'b1, 1'b0, 1'b0, 32'h3000_0000 + i);
        end
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("load_dfs_noswap", disp_bank, 1'b0);
        push(1'b1, 2047, 32'h3000_0000 + 2047);
        cyc(1'b1, 1'b0, 1'b1, 32'h3000_0000 + 2047);
        check("last_dfs_noswap", disp_bank, 1'b0);
        check("last_dfs_frames", frames_loaded, 8'd2);

        // Words while the completed frame awaits swap
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'hBAD0_0000 + i);
        check("overrun_set", overrun, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("f3_bank", disp_bank, 1'b1);
        check("f3_frames", frames_loaded, 8'd3);
        check("overrun_sticky", overrun, 1'b1);

        // Reset in the middle of a load
        cyc(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 500; i++) begin
            push(1'b0, i, 32'h4000_0000 + i);
            cyc(1'b1, 1'b0, 1'b0, 32'h4000_0000 + i);
        end
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 32'h5555_5555);
        check_reset_outputs("midrst");
        reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        check("first_at_zero_noshort", short_frame, 1'b0);
        for (int i = 0; i < 2048; i++) begin
            push(1'b1, i, 32'h6000_0000 + i);
            cyc(1'b1, 1'b0, 1'b0, 32'h6000_0000 + i);
        end
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("post_rst_bank", disp_bank, 1'b1);
        check("post_rst_frames", frames_loaded, 8'd1);
        cyc(1'b0, 1'b0, 1'b0, '0);
        check("queue_drained", exp_q.size(), 0);

        // 256 swaps on the small instance wrap frames_loaded to 0
        for (int k = 0; k < 256; k++) begin
            s_cyc(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < (1 << SAW); i++) s_cyc(1'b1, 1'b0, 1'b0);
            s_cyc(1'b0, 1'b0, 1'b1);
            check("wrap_frames", s_frames_loaded, (k + 1) % 256);
            check("wrap_bank", s_disp_bank, (k + 1) % 2);
        end
        check("wrap_ready", s_frame_ready, 1'b1);
        check("wrap_overrun", s_overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Sits between the SPI word receiver and the dual-port pixel RAM.
- Assembles a complete frame of packed pixel-pair words into the back bank of a double-buffered RAM.
- Swaps the back bank to the display only at a display frame boundary, so a partially loaded frame is never shown.
- Supplies the bank select and display-enable to the panel scan/PWM stage.

Parameters:
ADDR_W, 11, word address bits per bank; one frame = 2^ADDR_W words
WORD_W, 32, RAM word width (two 16-bit RGB555 pixels)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
word_data  in  WORD_W  received word from SPI receiver
word_valid  in  1  one-cycle strobe: word_data valid
word_first  in  1  one-cycle strobe: start of a new transfer (chip-select asserted)
disp_frame_start  in  1  one-cycle strobe from scan stage at start of each displayed frame
ram_we  out  1  RAM write enable
ram_waddr  out  ADDR_W+1  RAM write address; MSB = bank
ram_wdata  out  WORD_W  RAM write data
disp_bank  out  1  bank the scan stage reads (its RAM read-address MSB)
frame_ready  out  1  sticky; high once the first full frame is swapped in (display enable)
frames_loaded  out  8  count of completed swaps, wraps 255->0
short_frame  out  1  one-cycle pulse: transfer restarted before frame complete
overrun  out  1  sticky; words arrived while a completed frame awaited swap

Behaviour:
- Reset (clk edge with reset=1):
  - State IDLE; word counter 0; disp_bank=0, so the load bank is 1.
  - ram_we=0, ram_waddr=0, ram_wdata=0, frame_ready=0, frames_loaded=0, short_frame=0, overrun=0.
  - Reset overrides all other inputs in that cycle.
  - Reset mid-load discards the partial frame; RAM contents are not cleared.
- Load bank is always ~disp_bank.
- Write path is registered: an accepted word at cycle N gives ram_we=1 at N+1, with ram_waddr={~disp_bank, count} and ram_wdata=word_data from cycle N. Otherwise ram_we=0.
- IDLE:
  - word_valid without word_first is ignored (no write, no flag).
  - word_first -> LOAD with count=0.
  - word_first and word_valid in the same cycle: the word is written at address 0, count becomes 1, state -> LOAD.
- LOAD:
  - Each word_valid writes at count, then count increments.
  - Accepting a word at count = 2^ADDR_W-1 -> WAIT_SWAP; count wraps to 0.
  - word_first in LOAD with count != 0: short_frame pulses for 1 cycle and count restarts at 0. If word_valid coincides, the word is written at 0 and count becomes 1. Writes already made stay in the back bank and are later overwritten.
  - word_first in LOAD with count = 0: no pulse.
- WAIT_SWAP:
  - word_valid or word_first: no write; overrun set to 1 (sticky until reset).
  - disp_frame_start: disp_bank toggles, frame_ready <= 1, frames_loaded increments, state -> IDLE. All take effect together on the next cycle.
- disp_frame_start in the same cycle as the final word (LOAD -> WAIT_SWAP) does not swap; the swap waits for the next disp_frame_start.
- disp_frame_start in IDLE or LOAD: no effect.
- disp_bank changes only on a swap, so the displayed bank is never written (ram_waddr MSB != disp_bank whenever ram_we=1).

Test Plan:
- Reset, then word_first followed by 2048 word_valid words with data = index -> ram_we pulses 2048 times, addresses 0x800..0xFFF, data matches index each cycle after its strobe; no swap until disp_frame_start. On the pulse, the next cycle shows disp_bank=1, frame_ready=1, frames_loaded=1.
- Second full frame, then disp_frame_start -> writes go to 0x000..0x7FF, disp_bank=0, frames_loaded=2. Repeat 256 swaps -> frames_loaded wraps to 0.
- After 100 words, assert word_first together with word_valid (data 0xA5A5A5A5) -> short_frame high exactly 1 cycle; write at address {load bank,0} with 0xA5A5A5A5; a full frame still requires 2047 more words.
- Full frame loaded, no disp_frame_start, 3 more word_valid -> ram_we stays 0, overrun=1 and stays 1 after a later swap; disp_frame_start coincident with the last word -> no swap that cycle, swap on the next pulse.
- Assert reset at word 500 of a load -> all outputs at reset values next cycle. A new word_first plus full frame loads bank 1 from address 0.
- In IDLE, word_valid without word_first (10 words) -> no ram_we, no flags, counter remains 0.
